shift_reg_sequencer: RTL and testbench

Command sequencer and two-way arbiter for the 4-bit shifting register built from the gates library. Two requesters each issue one operation: parallel load, shift left, shift right, rotate left or rotate right, with a step count. The block grants one requester at a time, round-robin, and drives the register's mode, serial-in and parallel-data lines for the exact number of clock edges. It signals completion to the owner and then returns the register to hold.

---
 rtl/shift_reg_sequencer_if.sv | 31 +++
 rtl/shift_reg_sequencer.sv | 172 +++++++++++++++++
 tb/tb_shift_reg_sequencer.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/shift_reg_sequencer_if.sv
// Command/handshake bundle between the requesters, the shift register and the sequencer.
interface shift_reg_sequencer_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
);
    logic [1:0]       req;
    logic [2:0]       op0;
    logic [2:0]       op1;
    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;
    logic [WIDTH-1:0] data0;
    logic [WIDTH-1:0] data1;
    logic [WIDTH-1:0] q;
    logic [1:0]       gnt;
    logic             busy;
    logic             done;
    logic             owner;
    logic [1:0]       mode;
    logic             s_in;
    logic [WIDTH-1:0] d_out;

    modport master (
        output req, op0, op1, cnt0, cnt1, data0, data1, q,
        input  gnt, busy, done, owner, mode, s_in, d_out
    );

    modport slave (
        input  req, op0, op1, cnt0, cnt1, data0, data1, q,
        output gnt, busy, done, owner, mode, s_in, d_out
    );
endinterface

// File: rtl/shift_reg_sequencer.sv
// Round-robin two-requester sequencer that drives a shift register's mode,
// serial-in and parallel-load lines for a commanded number of clock edges.
module shift_reg_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    shift_reg_sequencer_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [2:0] OP_LOAD = 3'd0;
    localparam logic [2:0] OP_SHL  = 3'd1;
    localparam logic [2:0] OP_SHR  = 3'd2;
    localparam logic [2:0] OP_ROL  = 3'd3;
    localparam logic [2:0] OP_ROR  = 3'd4;

    localparam logic [1:0] M_HOLD  = 2'b00;
    localparam logic [1:0] M_LEFT  = 2'b01;
    localparam logic [1:0] M_RIGHT = 2'b10;
    localparam logic [1:0] M_LOAD  = 2'b11;

    state_t           state_q, state_d;
    logic             ptr_q, ptr_d;
    logic [2:0]       op_q, op_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [1:0]       gnt_q, gnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             owner_q, owner_d;
    logic [1:0]       mode_q, mode_d;
    logic [WIDTH-1:0] d_out_q, d_out_d;

    logic             win;
    logic [2:0]       win_op;
    logic [CNT_W-1:0] win_cnt;
    logic [WIDTH-1:0] win_data;
    logic [WIDTH-1:0] fb_mask;

    // On a tie the pointer names the requester that was not served last.
    always_comb begin
        if (bus.req == 2'b01) begin
            win = 1'b0;
        end else if (bus.req == 2'b10) begin
            win = 1'b1;
        end else begin
            win = ptr_q;
        end
        win_op   = win ? bus.op1   : bus.op0;
        win_cnt  = win ? bus.cnt1  : bus.cnt0;
        win_data = win ? bus.data1 : bus.data0;
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        op_d    = op_q;
        rem_d   = rem_q;
        data_d  = data_q;
        gnt_d   = 2'b00;
        busy_d  = busy_q;
        done_d  = 1'b0;
        owner_d = owner_q;
        mode_d  = mode_q;
        d_out_d = d_out_q;
        case (state_q)
            S_IDLE: begin
                if (|bus.req) begin
                    op_d       = win_op;
                    data_d     = win_data;
                    gnt_d[win] = 1'b1;
                    owner_d    = win;
                    ptr_d      = ~win;
                    busy_d     = 1'b1;
                    rem_d      = win_cnt - CNT_W'(1);
                    case (win_op)
                        OP_LOAD: begin
                            rem_d   = '0;
                            mode_d  = M_LOAD;
                            d_out_d = win_data;
                            state_d = S_RUN;
                        end
                        OP_SHL, OP_ROL, OP_SHR, OP_ROR: begin
                            if (win_cnt != '0) begin
                                mode_d  = (win_op == OP_SHL || win_op == OP_ROL) ? M_LEFT : M_RIGHT;
                                state_d = S_RUN;
                            end else begin
                                done_d  = 1'b1;
                                state_d = S_DONE;
                            end
                        end
                        default: begin
                            done_d  = 1'b1;
                            state_d = S_DONE;
                        end
                    endcase
                end
            end
            S_RUN: begin
                if (rem_q == '0) begin
                    mode_d  = M_HOLD;
                    d_out_d = '0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    rem_d = rem_q - CNT_W'(1);
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            ptr_q   <= 1'b0;
            op_q    <= '0;
            rem_q   <= '0;
            data_q  <= '0;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            owner_q <= 1'b0;
            mode_q  <= M_HOLD;
            d_out_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            op_q    <= op_d;
            rem_q   <= rem_d;
            data_q  <= data_d;
            gnt_q   <= gnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            owner_q <= owner_d;
            mode_q  <= mode_d;
            d_out_q <= d_out_d;
        end
    end

    // Rotates feed back the bit that falls off the far end of the register.
    always_comb begin
        fb_mask = '0;
        if (op_q == OP_ROL) begin
            fb_mask = {1'b1, {(WIDTH-1){1'b0}}};
        end else if (op_q == OP_ROR) begin
            fb_mask = WIDTH'(1);
        end
        if (state_q != S_RUN) begin
            bus.s_in = 1'b0;
        end else if (op_q == OP_SHL || op_q == OP_SHR) begin
            bus.s_in = data_q[0];
        end else begin
            bus.s_in = |(bus.q & fb_mask);
        end
    end

    assign bus.gnt   = gnt_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.owner = owner_q;
    assign bus.mode  = mode_q;
    assign bus.d_out = d_out_q;
endmodule

// File: tb/tb_shift_reg_sequencer.sv
// Directed bench for shift_reg_sequencer with a behavioural 4-bit shift register in the loop.
module tb_shift_reg_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [3:0] qreg = 4'b0000;
    int checks = 0;
    int failures = 0;

    shift_reg_sequencer_if #(.WIDTH(4), .CNT_W(3)) bif ();

    shift_reg_sequencer #(.WIDTH(4), .CNT_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    always #5 clk = ~clk;

    // The controlled register: left shift fills bit 0, right shift fills bit 3.
    always @(posedge clk) begin
        case (bif.mode)
            2'b01:   qreg <= {qreg[2:0], bif.s_in};
            2'b10:   qreg <= {bif.s_in, qreg[3:1]};
            2'b11:   qreg <= bif.d_out;
            default: qreg <= qreg;
        endcase
    end
    assign bif.q = qreg;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        bif.req = 2'b00;
        bif.op0 = 3'd0; bif.op1 = 3'd0;
        bif.cnt0 = 3'd0; bif.cnt1 = 3'd0;
        bif.data0 = 4'd0; bif.data1 = 4'd0;
        tick(); tick();
        chk("rst_gnt",   32'(bif.gnt),   32'd0);
        chk("rst_busy",  32'(bif.busy),  32'd0);
        chk("rst_done",  32'(bif.done),  32'd0);
        chk("rst_owner", 32'(bif.owner), 32'd0);
        chk("rst_mode",  32'(bif.mode),  32'd0);
        chk("rst_s_in",  32'(bif.s_in),  32'd0);
        chk("rst_d_out", 32'(bif.d_out), 32'd0);
        reset = 1'b0;

        // Load 1010 from requester 0
        bif.req = 2'b01; bif.op0 = 3'b000; bif.data0 = 4'b1010;
        tick();
        chk("ld_gnt",   32'(bif.gnt),   32'b01);
        chk("ld_busy",  32'(bif.busy),  32'd1);
        chk("ld_mode",  32'(bif.mode),  32'b11);
        chk("ld_d_out", 32'(bif.d_out), 32'b1010);
        chk("ld_done0", 32'(bif.done),  32'd0);
        bif.req = 2'b00;
        tick();
        chk("ld_q",     32'(qreg),      32'b1010);
        chk("ld_mode0", 32'(bif.mode),  32'b00);
        chk("ld_done",  32'(bif.done),  32'd1);
        chk("ld_busy2", 32'(bif.busy),  32'd1);
        chk("ld_gnt0",  32'(bif.gnt),   32'b00);
        tick();
        chk("ld_busy_off", 32'(bif.busy), 32'd0);
        chk("ld_done_off", 32'(bif.done), 32'd0);

        // Rotate left by 3 from requester 1
        bif.req = 2'b10; bif.op1 = 3'b011; bif.cnt1 = 3'd3;
        tick();
        chk("rol_gnt",   32'(bif.gnt),   32'b10);
        chk("rol_owner", 32'(bif.owner), 32'd1);
        chk("rol_mode",  32'(bif.mode),  32'b01);
        chk("rol_sin1",  32'(bif.s_in),  32'd1);
        bif.req = 2'b00;
        tick();
        chk("rol_q1",    32'(qreg),      32'b0101);
        chk("rol_sin2",  32'(bif.s_in),  32'd0);
        chk("rol_done1", 32'(bif.done),  32'd0);
        tick();
        chk("rol_q2",    32'(qreg),      32'b1010);
        chk("rol_sin3",  32'(bif.s_in),  32'd1);
        chk("rol_mode3", 32'(bif.mode),  32'b01);
        tick();
        chk("rol_q3",    32'(qreg),      32'b0101);
        chk("rol_mode0", 32'(bif.mode),  32'b00);
        chk("rol_done",  32'(bif.done),  32'd1);
        chk("rol_sin0",  32'(bif.s_in),  32'd0);
        tick();
        chk("rol_done_off", 32'(bif.done), 32'd0);
        chk("rol_busy_off", 32'(bif.busy), 32'd0);

        // Clear the register, then shift right twice with fill 1
        bif.req = 2'b01; bif.op0 = 3'b000; bif.data0 = 4'b0000;
        tick();
        bif.req = 2'b00;
        tick(); tick();
        chk("clr_q", 32'(qreg), 32'b0000);
        bif.req = 2'b01; bif.op0 = 3'b010; bif.cnt0 = 3'd2; bif.data0 = 4'b0001;
        tick();
        chk("shr_mode", 32'(bif.mode), 32'b10);
        chk("shr_sin",  32'(bif.s_in), 32'd1);
        bif.req = 2'b00;
        tick();
        chk("shr_q1",   32'(qreg),     32'b1000);
        chk("shr_mode1", 32'(bif.mode), 32'b10);
        tick();
        chk("shr_q2",   32'(qreg),     32'b1100);
        chk("shr_mode0", 32'(bif.mode), 32'b00);
        chk("shr_done", 32'(bif.done), 32'd1);
        tick();

        // Round-robin with both requesters loading continuously
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bif.req = 2'b11;
        bif.op0 = 3'b000; bif.data0 = 4'b0011;
        bif.op1 = 3'b000; bif.data1 = 4'b1100;
        tick();
        chk("rr_gnt_a",   32'(bif.gnt),   32'b01);
        chk("rr_owner_a", 32'(bif.owner), 32'd0);
        chk("rr_dout_a",  32'(bif.d_out), 32'b0011);
        tick();
        chk("rr_gap",     32'(bif.gnt),   32'b00);
        tick(); tick();
        chk("rr_gnt_b",   32'(bif.gnt),   32'b10);
        chk("rr_owner_b", 32'(bif.owner), 32'd1);
        chk("rr_dout_b",  32'(bif.d_out), 32'b1100);
        tick(); tick(); tick();
        chk("rr_gnt_c",   32'(bif.gnt),   32'b01);
        chk("rr_owner_c", 32'(bif.owner), 32'd0);
        tick(); tick(); tick();
        chk("rr_gnt_d",   32'(bif.gnt),   32'b10);
        chk("rr_owner_d", 32'(bif.owner), 32'd1);
        bif.req = 2'b00;
        tick(); tick();
        chk("rr_q",    32'(qreg),     32'b1100);
        chk("rr_idle", 32'(bif.busy), 32'd0);

        // Zero-count shift left: grant and done together, register untouched
        bif.req = 2'b01; bif.op0 = 3'b001; bif.cnt0 = 3'd0; bif.data0 = 4'b0001;
        tick();
        chk("z_gnt",  32'(bif.gnt),  32'b01);
        chk("z_done", 32'(bif.done), 32'd1);
        chk("z_mode", 32'(bif.mode), 32'b00);
        chk("z_busy", 32'(bif.busy), 32'd1);
        bif.req = 2'b00;
        tick();
        chk("z_busy_off", 32'(bif.busy), 32'd0);
        chk("z_mode2",    32'(bif.mode), 32'b00);
        chk("z_q",        32'(qreg),     32'b1100);

        // Invalid opcode behaves as a no-op
        bif.req = 2'b10; bif.op1 = 3'b101; bif.cnt1 = 3'd3;
        tick();
        chk("inv_gnt",  32'(bif.gnt),  32'b10);
        chk("inv_done", 32'(bif.done), 32'd1);
        chk("inv_mode", 32'(bif.mode), 32'b00);
        bif.req = 2'b00;
        tick();
        chk("inv_q", 32'(qreg), 32'b1100);

        // Reset during a 7-step shift left after 3 edges
        bif.req = 2'b01; bif.op0 = 3'b001; bif.cnt0 = 3'd7; bif.data0 = 4'b0001;
        tick();
        chk("rm_mode", 32'(bif.mode), 32'b01);
        bif.req = 2'b00;
        tick(); tick(); tick();
        chk("rm_q3",    32'(qreg),      32'b0111);
        chk("rm_busy3", 32'(bif.busy),  32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("rm_mode0", 32'(bif.mode),  32'b00);
        chk("rm_busy0", 32'(bif.busy),  32'd0);
        chk("rm_sin0",  32'(bif.s_in),  32'd0);
        chk("rm_owner", 32'(bif.owner), 32'd0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 9; i++) begin
            tick();
            chk("rm_no_done", 32'(bif.done), 32'd0);
        end
        chk("rm_q_final", 32'(qreg), 32'b0111);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
